hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipelined datapath.
- Resolves each ID-stage instruction's destination register (rt or rd, per RegDst).
- Tracks destinations through the EX, MEM and WB stages.
- Drives the ALU-operand forwarding mux selects and the load-use stall.
- Sits beside the ID/EX pipeline register and is the sole source of `stall`, `fwd_a_sel` and `fwd_b_sel`.

Parameters:
- RW, 5: register-address width.
- NREG_ZERO, 0: hard-wired zero register index; never a hazard source.
- CNT_W, 16: stall-counter width (optional feature only).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- hold, input, 1: global freeze (memory wait); no state updates while high.
- flush, input, 1: kill the ID instruction; it enters EX as a bubble.
- id_valid, input, 1: ID holds a real instruction.
- id_rs, input, RW: source register A.
- id_rt, input, RW: source register B, and destination candidate 0.
- id_rd, input, RW: destination candidate 1.
- id_uses_rs, input, 1: instruction reads rs.
- id_uses_rt, input, 1: instruction reads rt.
- id_reg_dst, input, 1: 0 selects rt as destination, 1 selects rd.
- id_reg_write, input, 1: instruction writes the register file.
- id_mem_read, input, 1: instruction is a load.
- stall, output, 1: hold PC and IF/ID, insert a bubble into EX.
- fwd_a_sel, output, 2: EX operand A source.
- fwd_b_sel, output, 2: EX operand B source.
- ex_dst, output, RW: destination address of the instruction in EX.
- wb_dst, output, RW: register-file write address.
- wb_we, output, 1: register-file write enable.
- stall_count, output, CNT_W: stall counter (`HZD_STALL_CNT_EN` only).

Behaviour:
- Forward codes:
  - 00: register file.
  - 01: MEM/WB result.
  - 10: EX/MEM result.
  - 11: reserved, never driven.
- Destination: `id_dst = id_reg_dst ? id_rd : id_rt`.
- A destination equal to NREG_ZERO is treated as no write (`wr` forced to 0 at capture).
- Stage state: (dst, wr, ld) for EX, (dst, wr) for MEM, (dst, wr) for WB.
- All stage state clears to 0 on reset.
- Every clk with `hold=0`:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID capture, or a bubble (`wr=0`, `ld=0`, `dst=0`, fwd=00) if `stall`, `flush` or `!id_valid`.
- With `hold=1`, all registers keep their values and the outputs are stable.
- stall (combinational):
  - Asserted when `id_valid & !flush & ex_ld & ex_wr`.
  - And additionally `(id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)`.
- Forwarding selects are computed in ID and registered into EX with the instruction. For each operand (rs→A, rt→B, only when the operand is used):
  - If `ex_wr & ex_dst==src & !ex_ld`: code 10.
  - Else if `mem_wr & mem_dst==src`: code 01.
  - Else: 00.
  - EX match has priority over MEM match.
- Load case: an EX match with `ex_ld=1` raises stall instead of forwarding. The following cycle the load is in MEM, and the re-evaluated select becomes 01.
- WB-stage matches need no forward. The register file writes in the first half-cycle and reads in the second.
- Reset values:
  - `fwd_a_sel`, `fwd_b_sel` = 00.
  - `ex_dst`, `wb_dst` = 0.
  - `wb_we` = 0.
  - `stall` = 0, since all `wr`/`ld` bits are cleared.
- Reset mid-operation: in-flight destinations are discarded and no spurious `wb_we` is produced.
- Simultaneous `flush` and load-use condition: flush wins, `stall=0`, bubble inserted.
- Simultaneous `hold` and `stall`:
  - `stall` stays asserted (combinational).
  - No bubble is inserted until `hold` falls.
- Latency: the forward select is valid in the same cycle the instruction is in EX (one register after ID).

Optional Feature:
- Macro: `HZD_STALL_CNT_EN`.
- When defined:
  - `stall_count` is a CNT_W-bit counter that increments on each clk with `stall & !hold`.
  - It saturates at all-ones and resets to 0.
- When not defined:
  - The counter logic is absent.
  - `stall_count` is tied to 0.

Decomposition:
- Shared package `hzd_pkg`:
  - Forward-code constants: `FWD_RF=2'b00`, `FWD_WB=2'b01`, `FWD_EXM=2'b10`.
  - RW.
  - Stage-record typedef {dst, wr, ld}.
- One sub-module, `hzd_dst_stage`:
  - A single pipeline stage register with hold, bubble-insert and asynchronous reset.
  - Instantiated three times (EX, MEM, WB).

Test Plan:
1. Reset: `rst_n=0` with activity on all inputs, then release → `stall=0`, fwd=00, `wb_we=0` for 3 cycles of bubbles.
2. EX→EX forwarding: `add $3` (`rd=3`, `reg_dst=1`) followed by `sub` reading rs=3 → second instruction in EX has `fwd_a_sel=10`.
3. MEM→EX forwarding: `add $3`, `nop`, then `or` reading rt=3 → `fwd_b_sel=01`. With both EX and MEM writing $3 → 10.
4. Load-use: `lw $5` (`reg_dst=0`, `rt=5`) followed by `add` reading rs=5 → `stall=1` for exactly 1 cycle, bubble in EX, then `fwd_a_sel=01`.
5. Zero register: `lw $0` followed by a read of $0 → `stall=0`, fwd=00.
6. Corner events:
   - Load-use with `flush=1` → `stall=0`.
   - Load-use with `hold=1` for 4 cycles → state frozen, `stall` held.
   - `HZD_STALL_CNT_EN` defined → `stall_count` increments by 1 per stall cycle only.

Source files
------------

// File: rtl/hzd_pkg.sv
// Shared types and constants for the hazard/forwarding controller:
// forward-select codes, register-address width and the per-stage destination record.
package hzd_pkg;

    localparam int RW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    typedef struct packed {
        logic [RW-1:0] dst;
        logic          wr;
        logic          ld;
    } stage_t;

    // A load sitting in EX cannot forward yet; it is left to fall back on the MEM match
    // (which the load-use stall guarantees on the following cycle).
    function automatic logic [1:0] fwd_select(input logic          used,
                                              input logic [RW-1:0] src,
                                              input stage_t        ex,
                                              input stage_t        mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (ex.wr && (ex.dst == src) && !ex.ld) begin
                sel = FWD_EXM;
            end else if (mem.wr && (mem.dst == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hzd_dst_stage.sv
// One pipeline slot of destination tracking: holds its record while frozen,
// loads an empty record when a bubble is requested.
module hzd_dst_stage
    import hzd_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d = bubble ? stage_t'('0) : d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall and ALU operand forwarding control for the 5-stage pipeline.
// Optional macro HZD_STALL_CNT_EN adds a saturating count of stall cycles on stall_count.
module hazard_fwd_ctrl
    import hzd_pkg::*;
#(
    parameter int RW        = 5,
    parameter int NREG_ZERO = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [RW-1:0]    ex_dst,
    output logic [RW-1:0]    wb_dst,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_count
);

    logic [RW-1:0] id_dst;
    stage_t        id_rec;
    stage_t        ex_stage;
    stage_t        mem_stage;
    stage_t        wb_stage;
    logic          load_use;
    logic          insert_bubble;
    logic [1:0]    fwd_a_q, fwd_a_d;
    logic [1:0]    fwd_b_q, fwd_b_d;
    logic          unused_wb_ld;

    // Writes to the zero register are dropped here so no later stage can match on it.
    always_comb begin
        id_dst     = id_reg_dst ? id_rd : id_rt;
        id_rec.dst = id_dst;
        id_rec.wr  = id_reg_write && (id_dst != RW'(NREG_ZERO));
        id_rec.ld  = id_mem_read;
    end

    always_comb begin
        load_use = ex_stage.wr && ex_stage.ld &&
                   ((id_uses_rs && (id_rs == ex_stage.dst)) ||
                    (id_uses_rt && (id_rt == ex_stage.dst)));
        stall         = id_valid && !flush && load_use;
        insert_bubble = stall || flush || !id_valid;
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!hold) begin
            fwd_a_d = insert_bubble ? FWD_RF : fwd_select(id_uses_rs, id_rs, ex_stage, mem_stage);
            fwd_b_d = insert_bubble ? FWD_RF : fwd_select(id_uses_rt, id_rt, ex_stage, mem_stage);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    hzd_dst_stage u_ex_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .bubble (insert_bubble),
        .d      (id_rec),
        .q      (ex_stage)
    );

    hzd_dst_stage u_mem_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .bubble (1'b0),
        .d      (ex_stage),
        .q      (mem_stage)
    );

    hzd_dst_stage u_wb_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .bubble (1'b0),
        .d      (mem_stage),
        .q      (wb_stage)
    );

    assign fwd_a_sel    = fwd_a_q;
    assign fwd_b_sel    = fwd_b_q;
    assign ex_dst       = ex_stage.dst;
    assign wb_dst       = wb_stage.dst;
    assign wb_we        = wb_stage.wr;
    assign unused_wb_ld = wb_stage.ld;

`ifdef HZD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline scenarios plus a long
// randomized run compared every cycle against an in-flight instruction model.
module tb_hazard_fwd_ctrl;

    localparam int RW    = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold = 1'b0;
    logic             flush = 1'b0;
    logic             id_valid = 1'b0;
    logic [RW-1:0]    id_rs = '0;
    logic [RW-1:0]    id_rt = '0;
    logic [RW-1:0]    id_rd = '0;
    logic             id_uses_rs = 1'b0;
    logic             id_uses_rt = 1'b0;
    logic             id_reg_dst = 1'b0;
    logic             id_reg_write = 1'b0;
    logic             id_mem_read = 1'b0;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [RW-1:0]    ex_dst;
    logic [RW-1:0]    wb_dst;
    logic             wb_we;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_dst   (id_reg_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .stall        (stall),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .ex_dst       (ex_dst),
        .wb_dst       (wb_dst),
        .wb_we        (wb_we),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Instructions in flight, youngest first: [0] is in EX, [1] in MEM, [2] in WB.
    typedef struct {
        logic [RW-1:0] dst;
        logic          wr;
        logic          ld;
        logic [1:0]    fa;
        logic [1:0]    fb;
    } flight_t;

    localparam flight_t EMPTY = '{dst: '0, wr: 1'b0, ld: 1'b0, fa: 2'b00, fb: 2'b00};

    flight_t          flight [3];
    logic [CNT_W-1:0] stallsSeen;

    function automatic logic writesReg(input flight_t f, input logic [RW-1:0] r);
        return f.wr && (f.dst == r);
    endfunction

    // Producer one slot ahead supplies the EX/MEM result unless it is a load; two ahead supplies MEM/WB.
    function automatic logic [1:0] srcCode(input logic used, input logic [RW-1:0] r,
                                           input flight_t ahead1, input flight_t ahead2);
        if (!used) return 2'b00;
        if (writesReg(ahead1, r) && !ahead1.ld) return 2'b10;
        if (writesReg(ahead2, r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic modelStall();
        logic needsLoad;
        needsLoad = (id_uses_rs && writesReg(flight[0], id_rs)) ||
                    (id_uses_rt && writesReg(flight[0], id_rt));
        return id_valid && !flush && flight[0].ld && needsLoad;
    endfunction

    function automatic flight_t nextEntry();
        flight_t e;
        e = EMPTY;
        if (id_valid && !flush && !modelStall()) begin
            e.dst = id_reg_dst ? id_rd : id_rt;
            e.wr  = id_reg_write && (e.dst != 0);
            e.ld  = id_mem_read;
            e.fa  = srcCode(id_uses_rs, id_rs, flight[0], flight[1]);
            e.fb  = srcCode(id_uses_rt, id_rt, flight[0], flight[1]);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flight[0]  <= EMPTY;
            flight[1]  <= EMPTY;
            flight[2]  <= EMPTY;
            stallsSeen <= '0;
        end else if (!hold) begin
            flight[2] <= flight[1];
            flight[1] <= flight[0];
            flight[0] <= nextEntry();
            if (modelStall() && (stallsSeen != {CNT_W{1'b1}})) stallsSeen <= stallsSeen + 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("stall",  32'(stall),     32'(modelStall()));
        checkOutput("fwd_a",  32'(fwd_a_sel), 32'(flight[0].fa));
        checkOutput("fwd_b",  32'(fwd_b_sel), 32'(flight[0].fb));
        checkOutput("ex_dst", 32'(ex_dst),    32'(flight[0].dst));
        checkOutput("wb_dst", 32'(wb_dst),    32'(flight[2].dst));
        checkOutput("wb_we",  32'(wb_we),     32'(flight[2].wr));
`ifdef HZD_STALL_CNT_EN
        checkOutput("stall_count", 32'(stall_count), 32'(stallsSeen));
`else
        checkOutput("stall_count", 32'(stall_count), 32'd0);
`endif
    end

    task automatic applyStimulus(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic [RW-1:0] rd, input logic urs, input logic urt,
                                 input logic rdst, input logic rw, input logic mr,
                                 input logic fl, input logic hd);
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_reg_dst   = rdst;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        hold         = hd;
    endtask

    task automatic applyNops(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1, 1, 1'($urandom_range(0, 1)), 1, 1, 0, 0);
            @(negedge clk);
            checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
            checkOutput("rst_stall", 32'(stall), 32'd0);
        end
        applyNops(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_wb_we", 32'(wb_we), 32'd0);
            checkOutput("post_rst_stall", 32'(stall), 32'd0);
            checkOutput("post_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
            @(posedge clk);
        end

        // EX->EX: add $3 then sub reading rs=3
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 3, 4, 6, 1, 1, 1, 1, 0, 0, 0);
        applyNops(1);
        @(negedge clk);
        checkOutput("exex_fwd_a", 32'(fwd_a_sel), 32'b10);
        checkOutput("exex_fwd_b", 32'(fwd_b_sel), 32'b00);
        applyNops(3);

        // MEM->EX: add $3, nop, or reading rt=3
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
        applyNops(1);
        applyStimulus(1, 1, 3, 7, 1, 1, 1, 1, 0, 0, 0);
        applyNops(1);
        @(negedge clk);
        checkOutput("memex_fwd_b", 32'(fwd_b_sel), 32'b01);
        checkOutput("memex_fwd_a", 32'(fwd_a_sel), 32'b00);
        applyNops(3);

        // Both EX and MEM write $3: nearest producer wins
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 3, 7, 1, 1, 1, 1, 0, 0, 0);
        applyNops(1);
        @(negedge clk);
        checkOutput("prio_fwd_b", 32'(fwd_b_sel), 32'b10);
        applyNops(3);

        // Load-use: lw $5 then add reading rs=5
        applyStimulus(1, 1, 5, 9, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("lu_stall", 32'(stall), 32'd1);
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("lu_stall_drop", 32'(stall), 32'd0);
        checkOutput("lu_bubble_dst", 32'(ex_dst), 32'd0);
        applyNops(1);
        @(negedge clk);
        checkOutput("lu_fwd_a", 32'(fwd_a_sel), 32'b01);
        applyNops(3);

        // Zero register is never a hazard
        applyStimulus(1, 1, 0, 9, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 8, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("zero_stall", 32'(stall), 32'd0);
        applyNops(1);
        @(negedge clk);
        checkOutput("zero_fwd_a", 32'(fwd_a_sel), 32'b00);
        applyNops(3);

        // Flush beats load-use
        applyStimulus(1, 1, 5, 9, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 1, 0);
        @(negedge clk);
        checkOutput("flush_stall", 32'(stall), 32'd0);
        applyNops(1);
        @(negedge clk);
        checkOutput("flush_bubble_dst", 32'(ex_dst), 32'd0);
        applyNops(3);

        // Load-use under hold: frozen for four cycles, stall stays up
        applyStimulus(1, 1, 5, 9, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("hold_stall", 32'(stall), 32'd1);
            checkOutput("hold_ex_dst", 32'(ex_dst), 32'd5);
            if (k < 3) @(posedge clk);
        end
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("unhold_stall", 32'(stall), 32'd1);
        applyStimulus(1, 5, 2, 8, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("unhold_bubble", 32'(ex_dst), 32'd0);
        applyNops(1);
        @(negedge clk);
        checkOutput("unhold_fwd_a", 32'(fwd_a_sel), 32'b01);
        applyNops(3);

        // Randomized run over a small register set to provoke frequent hazards
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 9) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 7) == 0));
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        applyNops(1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
